// File: rtl/sram_axis_reader_pkg.sv
// Shared constants for the SRAM stream reader: SRAM geometry and the
// reader FSM state encoding.
package sram_axis_reader_pkg;

  localparam int NUM_SRAMS      = 8;
  localparam int MAX_ADDR_WIDTH = 12;
  localparam int SRAM_WIDTH_O   = 64;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2,
    RD_DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// Small synchronous FIFO holding {last, data} read returns. Push and pop in
// the same cycle are both honoured; the head entry is read straight from the
// storage array, so it stays stable until it is popped.
module sram_rd_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;

  // A pop on an empty FIFO is dropped so the pointers can never cross.
  assign pop_ok = pop && (count != '0);
  assign dout   = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_axis_reader.sv
// Streams a contiguous SRAM bank region out as an AXI4-Stream master.
// Reads are issued only when a FIFO slot is guaranteed for the returning
// word (fifo count + in-flight read < depth), so tready never reaches the
// SRAM enable combinationally and the FIFO cannot overflow.
// Optional macro SRAM_READER_PERF_EN builds the stall/beat counters.
//
// Stream handshake: a beat transfers on a cycle where m_axis_tvalid and
// m_axis_tready are both high; once tvalid is raised it stays high with
// tdata/tlast unchanged until that transfer happens.
module sram_axis_reader
  import sram_axis_reader_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_WIDTH_O,
  parameter int ADDR_WIDTH = MAX_ADDR_WIDTH,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            bank_idx_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sram_out_en,
  output logic [2:0]            sram_out_idx,
  output logic [ADDR_WIDTH-1:0] sram_out_addr,
  input  logic [DATA_WIDTH-1:0] sram_out_data,
  input  logic                  sram_out_stall,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           perf_stall_cycles_o,
  output logic [31:0]           perf_beats_o,
  output logic [1:0]            state_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_t             state;
  logic [2:0]            bank_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic                  busy_q;
  logic                  done_q;

  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic                  fifo_valid;
  logic                  pop;
  logic [CW:0]           used;
  logic                  rd_en;
  logic                  last_issue;

  assign fifo_valid = (fifo_count != '0);
  assign pop        = fifo_valid && m_axis_tready;
  assign used       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign rd_en      = (state == RD_READ) && (used < (CW+1)'(FIFO_DEPTH)) && !sram_out_stall;
  assign last_issue = (remaining == LEN_WIDTH'(1));

  // Command FSM: latch the request, walk the address range, then wait for
  // the stream to empty before the completion pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RD_IDLE;
      bank_q    <= '0;
      addr_q    <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (start_i) begin
            bank_q    <= bank_idx_i;
            addr_q    <= base_addr_i;
            remaining <= len_i;
            if (len_i == '0) begin
              state  <= RD_DONE;
              done_q <= 1'b1;
            end else begin
              state  <= RD_READ;
              busy_q <= 1'b1;
            end
          end
        end
        RD_READ: begin
          if (rd_en) begin
            addr_q    <= addr_q + 1'b1;
            remaining <= remaining - 1'b1;
            if (last_issue) state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          // Finish on the cycle the final beat leaves so done follows it directly.
          if (!inflight && (fifo_count == '0 || (fifo_count == CW'(1) && pop))) begin
            state  <= RD_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: begin
          done_q <= 1'b0;
          state  <= RD_IDLE;
        end
      endcase
    end
  end

  // One-cycle read latency tracker; the returning word is pushed next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && last_issue;
    end
  end

  sram_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({inflight_last, sram_out_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign sram_out_en   = rd_en;
  assign sram_out_idx  = bank_q;
  assign sram_out_addr = rd_en ? addr_q : '0;
  assign m_axis_tvalid = fifo_valid;
  assign m_axis_tdata  = fifo_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = fifo_valid && fifo_dout[DATA_WIDTH];
  assign state_o       = state;

`ifdef SRAM_READER_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] beat_cnt;

  // Free-running stream counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      if (fifo_valid && !m_axis_tready) stall_cnt <= stall_cnt + 1'b1;
      if (pop)                          beat_cnt  <= beat_cnt + 1'b1;
    end
  end

  assign perf_stall_cycles_o = stall_cnt;
  assign perf_beats_o        = beat_cnt;
`else
  assign perf_stall_cycles_o = '0;
  assign perf_beats_o        = '0;
`endif

endmodule

// File: tb/tb_sram_axis_reader.sv
// Directed bench for sram_axis_reader: SRAM read model, stream monitor with
// an expected queue, and a linear sequence of scenarios.
module tb_sram_axis_reader;
  import sram_axis_reader_pkg::*;

  localparam int DW = 64;
  localparam int AW = 12;
  localparam int LW = 16;

`ifdef SRAM_READER_PERF_EN
  localparam logic [31:0] EXP_BEATS4 = 32'd4;
  localparam logic [31:0] EXP_STALL2 = 32'd2;
`else
  localparam logic [31:0] EXP_BEATS4 = 32'd0;
  localparam logic [31:0] EXP_STALL2 = 32'd0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start_i;
  logic [2:0]    bank_idx_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] len_i;
  logic          busy_o, done_o;
  logic          sram_out_en;
  logic [2:0]    sram_out_idx;
  logic [AW-1:0] sram_out_addr;
  logic [DW-1:0] sram_out_data;
  logic          sram_out_stall;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [31:0]   perf_stall_cycles_o, perf_beats_o;
  logic [1:0]    state_o;

  sram_axis_reader #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .LEN_WIDTH (LW), .FIFO_DEPTH (4)
  ) dut (
    .clk (clk), .rst (rst), .start_i (start_i), .bank_idx_i (bank_idx_i),
    .base_addr_i (base_addr_i), .len_i (len_i), .busy_o (busy_o), .done_o (done_o),
    .sram_out_en (sram_out_en), .sram_out_idx (sram_out_idx),
    .sram_out_addr (sram_out_addr), .sram_out_data (sram_out_data),
    .sram_out_stall (sram_out_stall), .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid), .m_axis_tready (m_axis_tready),
    .m_axis_tlast (m_axis_tlast), .perf_stall_cycles_o (perf_stall_cycles_o),
    .perf_beats_o (perf_beats_o), .state_o (state_o)
  );

  // ---------------- SRAM model ----------------
  function automatic logic [63:0] data_of(input logic [2:0] b, input logic [AW-1:0] a);
    return 64'(a) + 64'h90 + ((64'(b) ^ 64'd2) << 40);
  endfunction

  always @(posedge clk) begin
    if (sram_out_en) sram_out_data <= data_of(sram_out_idx, sram_out_addr);
    else             sram_out_data <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [DW:0]   exp_q[$];
  int            beats = 0, reads = 0, done_cnt = 0, outstanding = 0;
  int            first_beat_cyc = -1, last_beat_cyc = -1, done_cyc = -1;
  logic [AW-1:0] exp_addr = '0;
  logic [2:0]    exp_bank = '0;
  bit            prev_stalled = 1'b0;
  logic [DW-1:0] held_data = '0;

  // Stream / read-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst) begin
      prev_stalled = 1'b0;
      outstanding  = 0;
    end else begin
      if (prev_stalled) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", m_axis_tdata, held_data);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy_o, 0);
      end
      if (sram_out_stall) check("en_during_stall", sram_out_en, 0);
      if (sram_out_en) begin
        check("credit", 64'(outstanding < 4), 1);
        check("rd_addr", sram_out_addr, exp_addr);
        check("rd_bank", sram_out_idx, exp_bank);
        exp_addr = exp_addr + 1'b1;
        reads++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL extra_beat observed=%0h expected=none", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e[DW-1:0]);
          check("tlast", m_axis_tlast, e[DW]);
        end
        if (beats == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beats++;
      end
      prev_stalled = m_axis_tvalid && !m_axis_tready;
      held_data    = m_axis_tdata;
      outstanding += int'(sram_out_en) - int'(m_axis_tvalid && m_axis_tready);
    end
  end

  // ---------------- driver tasks ----------------
  int t_start = 0;

  task automatic push_exp(input logic [2:0] b, input logic [AW-1:0] base, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({1'(i == len - 1), data_of(b, AW'(base + AW'(i)))});
  endtask

  // Returns positioned at cycle T+1 (#1 after the edge that accepted start).
  task automatic start_xfer(input logic [2:0] b, input logic [AW-1:0] base, input logic [LW-1:0] len);
    exp_bank = b;
    exp_addr = base;
    beats = 0;
    reads = 0;
    first_beat_cyc = -1;
    last_beat_cyc = -1;
    @(posedge clk); #1;
    bank_idx_i = b; base_addr_i = base; len_i = len; start_i = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (toggle) m_axis_tready = ~m_axis_tready;
      if (done_cnt != d0) break;
    end
    check("done_seen", 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic run_basic();
    exp_q.push_back({1'b0, 64'hA0});
    exp_q.push_back({1'b0, 64'hA1});
    exp_q.push_back({1'b0, 64'hA2});
    exp_q.push_back({1'b1, 64'hA3});
    m_axis_tready = 1'b1;
    start_xfer(3'd2, AW'('h10), LW'(4));
    check("basic_busy_t1", busy_o, 1);
    check("basic_en_t1", sram_out_en, 1);
    check("basic_valid_t1", m_axis_tvalid, 0);
    wait_done(30, 1'b0);
    check("basic_first_beat", 64'(first_beat_cyc), 64'(t_start + 3));
    check("basic_last_beat", 64'(last_beat_cyc), 64'(t_start + 6));
    check("basic_done_cyc", 64'(done_cyc), 64'(t_start + 7));
    check("basic_beats", 64'(beats), 4);
    check("basic_reads", 64'(reads), 4);
    check("basic_q_empty", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    start_i = 0; bank_idx_i = 0; base_addr_i = 0; len_i = 0;
    sram_out_stall = 0; m_axis_tready = 0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", m_axis_tvalid, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_en", sram_out_en, 0);
    check("rst_addr", sram_out_addr, 0);
    check("rst_idx", sram_out_idx, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_state", state_o, RD_IDLE);
    check("rst_perf_beats", perf_beats_o, 0);
    check("rst_perf_stall", perf_stall_cycles_o, 0);
    rst = 1'b1;

    // Basic transfer
    run_basic();

    // Backpressure: tready toggles every cycle
    push_exp(3'd1, AW'('h100), 8);
    start_xfer(3'd1, AW'('h100), LW'(8));
    wait_done(80, 1'b1);
    check("bp_beats", 64'(beats), 8);
    check("bp_reads", 64'(reads), 8);
    check("bp_q_empty", 64'(exp_q.size()), 0);

    // Arbiter stall for 3 cycles starting at T+2
    m_axis_tready = 1'b1;
    push_exp(3'd3, AW'('h20), 6);
    start_xfer(3'd3, AW'('h20), LW'(6));
    @(posedge clk); #1;
    sram_out_stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sram_out_stall = 1'b0;
    wait_done(40, 1'b0);
    check("stall_done_cyc", 64'(done_cyc), 64'(t_start + 12));
    check("stall_beats", 64'(beats), 6);
    check("stall_reads", 64'(reads), 6);

    // Zero length
    d0 = done_cnt;
    start_xfer(3'd0, AW'(5), LW'(0));
    check("len0_done_t1", done_o, 1);
    check("len0_busy_t1", busy_o, 0);
    check("len0_en_t1", sram_out_en, 0);
    repeat (3) @(posedge clk);
    #1;
    check("len0_reads", 64'(reads), 0);
    check("len0_beats", 64'(beats), 0);
    check("len0_done_cnt", 64'(done_cnt), 64'(d0 + 1));

    // Address wrap
    push_exp(3'd6, AW'('hFFE), 4);
    start_xfer(3'd6, AW'('hFFE), LW'(4));
    wait_done(30, 1'b0);
    check("wrap_beats", 64'(beats), 4);
    check("wrap_q_empty", 64'(exp_q.size()), 0);

    // Start while busy is ignored
    push_exp(3'd4, AW'('h30), 3);
    start_xfer(3'd4, AW'('h30), LW'(3));
    bank_idx_i = 3'd5; base_addr_i = AW'('h40); len_i = LW'(2); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(30, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("ign_busy", busy_o, 0);
    check("ign_state", state_o, RD_IDLE);
    check("ign_beats", 64'(beats), 3);
    check("ign_reads", 64'(reads), 3);

    // Reset mid-transfer with three words queued
    m_axis_tready = 1'b0;
    start_xfer(3'd7, AW'(0), LW'(8));
    repeat (4) @(posedge clk);
    #1;
    check("mid_valid_pre", m_axis_tvalid, 1);
    check("mid_en_full", sram_out_en, 0);
    check("mid_reads_pre", 64'(reads), 4);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_valid_post", m_axis_tvalid, 0);
    check("mid_busy_post", busy_o, 0);
    check("mid_state_post", state_o, RD_IDLE);
    check("mid_en_post", sram_out_en, 0);
    rst = 1'b1;
    exp_q.delete();
    run_basic();
    check("mid_perf_beats", perf_beats_o, EXP_BEATS4);
    check("mid_perf_stall", perf_stall_cycles_o, 0);

    // Perf counters: basic transfer with two stalled beats
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_axis_tready = 1'b1;
    push_exp(3'd2, AW'('h10), 4);
    start_xfer(3'd2, AW'('h10), LW'(4));
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    wait_done(30, 1'b0);
    check("perf_done_cyc", 64'(done_cyc), 64'(t_start + 9));
    check("perf_beats", perf_beats_o, EXP_BEATS4);
    check("perf_stall", perf_stall_cycles_o, EXP_STALL2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
